// File: rtl/cgra_input_stream_engine.sv
// cgra_input_stream_engine
//   Fetches NUM_CH strided word streams from memory over an in-order read
//   request/response port. Each stream is buffered in a per-channel FIFO and
//   presented to the CGRA input nodes as a valid/ready stream. Requests are
//   issued round-robin. A channel only issues when its FIFO has space for the
//   word, counting both the words held and the reads still in flight, so a
//   response always has somewhere to land.
//
// Optional build macro: CGRA_STREAM_PERF_EN adds the stall_cnt_o and
//   run_cycles_o performance counters.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start pulse, honoured only while idle
//   base_addr_i/size_i/stride_i  per-channel byte base, word count, byte stride
//   busy_o, done_o       busy while not idle; done pulses on the last delivery
//   mem_req_*            registered read request (valid/ready, byte address)
//   mem_rsp_*            in-order read data; ready is tied high
//   data_o/valid_o/ready_i  per-channel output streams

// Per-channel address generator, credit tracking and output FIFO.
module cgra_ise_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [SIZE_WIDTH-1:0] i_size,
  input  logic [SIZE_WIDTH-1:0] i_stride,
  input  logic                  i_issue,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_cur_addr,
  output logic                  o_can_issue,
  output logic                  o_rem_zero,
  output logic                  o_empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [SIZE_WIDTH-1:0] r_rem, r_stride;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_inflight, r_cnt;
  logic [PW-1:0]         r_wr, r_rd;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  w_pop;
  logic [CW:0]           w_used;

  assign o_empty     = (r_cnt == '0);
  assign o_valid     = !o_empty;
  // Gated so the output reads zero out of reset and whenever empty.
  assign o_data      = o_empty ? '0 : r_mem[r_rd];
  assign w_pop       = o_valid && i_ready;
  assign o_cur_addr  = r_addr;
  assign o_rem_zero  = (r_rem == '0);
  assign w_used      = {1'b0, r_cnt} + {1'b0, r_inflight};
  assign o_can_issue = !o_rem_zero && (w_used < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rem      <= '0;
      r_stride   <= '0;
      r_addr     <= '0;
      r_inflight <= '0;
      r_cnt      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      if (i_load) begin
        r_rem    <= i_size;
        r_addr   <= i_base;
        r_stride <= i_stride;
      end else if (i_issue) begin
        r_rem  <= r_rem - 1'b1;
        r_addr <= r_addr + ADDR_WIDTH'(r_stride);   // wraps modulo 2^ADDR_WIDTH
      end
      if (i_issue && !i_push)      r_inflight <= r_inflight + 1'b1;
      else if (!i_issue && i_push) r_inflight <= r_inflight - 1'b1;
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (i_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!i_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr] <= i_push_data;
  end
endmodule

module cgra_input_stream_engine #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] base_addr_i,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] size_i,
  input  logic [NUM_CH*SIZE_WIDTH-1:0] stride_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]        mem_rsp_data_i,
  output logic                         mem_rsp_ready_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  input  logic [NUM_CH-1:0]            ready_i
`ifdef CGRA_STREAM_PERF_EN
  ,
  output logic [NUM_CH*32-1:0]         stall_cnt_o,
  output logic [31:0]                  run_cycles_o
`endif
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int QW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  typedef struct packed {
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CHW-1:0]        ch;
  } req_t;

  state_e         r_state, w_next;
  req_t           r_req;
  logic [CHW-1:0] r_ptr;
  logic [OW-1:0]  r_outst;
  logic [CHW-1:0] r_idq [MAX_OUTSTANDING];   // channel of each in-flight read
  logic [QW-1:0]  r_idq_wr, r_idq_rd;

  logic w_start, w_hs, w_rsp, w_room, w_sel_found, w_all_rem_zero, w_drain_done;
  logic [CHW-1:0] w_sel_ch, w_head;
  logic [NUM_CH-1:0] w_issue, w_push, w_can_issue, w_rem_zero, w_empty, w_elig;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] w_cur_addr;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_start        = (r_state == S_IDLE) && start_i;
  assign w_hs           = r_req.vld && mem_req_ready_i;
  // Responses with no recorded request (e.g. stragglers after reset) are dropped.
  assign w_rsp          = mem_rsp_valid_i && (r_outst != '0);
  assign w_head         = r_idq[r_idq_rd];
  assign w_room         = r_outst < OW'(MAX_OUTSTANDING);
  assign w_elig         = w_room ? w_can_issue : '0;
  assign w_all_rem_zero = &w_rem_zero;
  assign w_drain_done   = (r_outst == '0) && (&w_empty);

  assign mem_req_valid_o = r_req.vld;
  assign mem_req_addr_o  = r_req.addr;
  assign mem_rsp_ready_o = 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign w_issue[c] = w_hs && (r_req.ch == CHW'(c));
    assign w_push[c]  = w_rsp && (w_head == CHW'(c));
    cgra_ise_lane #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .SIZE_WIDTH(SIZE_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_load      (w_start),
      .i_base      (base_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_size      (size_i[c*SIZE_WIDTH +: SIZE_WIDTH]),
      .i_stride    (stride_i[c*SIZE_WIDTH +: SIZE_WIDTH]),
      .i_issue     (w_issue[c]),
      .i_push      (w_push[c]),
      .i_push_data (mem_rsp_data_i),
      .i_ready     (ready_i[c]),
      .o_valid     (valid_o[c]),
      .o_data      (data_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .o_cur_addr  (w_cur_addr[c]),
      .o_can_issue (w_can_issue[c]),
      .o_rem_zero  (w_rem_zero[c]),
      .o_empty     (w_empty[c])
    );
  end

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      automatic int idx = int'(r_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!w_sel_found && w_elig[idx]) begin
        w_sel_found = 1'b1;
        w_sel_ch    = CHW'(idx);
      end
    end
  end

  // A new request is only registered while none is pending, so counters seen
  // at selection time already include the previous handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req    <= '0;
      r_ptr    <= '0;
      r_outst  <= '0;
      r_idq_wr <= '0;
      r_idq_rd <= '0;
    end else begin
      if (w_start)   r_ptr <= '0;
      else if (w_hs) r_ptr <= (r_req.ch == CHW'(NUM_CH-1)) ? '0 : r_req.ch + 1'b1;
      if (w_hs) r_req.vld <= 1'b0;
      else if (r_state == S_RUN && !r_req.vld && w_sel_found)
        r_req <= '{vld: 1'b1, addr: w_cur_addr[w_sel_ch], ch: w_sel_ch};
      if (w_hs)  r_idq_wr <= qinc(r_idq_wr);
      if (w_rsp) r_idq_rd <= qinc(r_idq_rd);
      if (w_hs && !w_rsp)      r_outst <= r_outst + 1'b1;
      else if (!w_hs && w_rsp) r_outst <= r_outst - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs) r_idq[r_idq_wr] <= r_req.ch;
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_next = S_RUN;
      S_RUN:   if (w_all_rem_zero && !r_req.vld) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != S_IDLE);
    done_o = (r_state == S_DRAIN) && w_drain_done;
  end

`ifdef CGRA_STREAM_PERF_EN
  logic [31:0]             r_run_cycles;
  logic [NUM_CH-1:0][31:0] r_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run_cycles <= '0;
      r_stall      <= '0;
    end else if (w_start) begin
      r_run_cycles <= '0;
      r_stall      <= '0;
    end else if (busy_o) begin
      if (r_run_cycles != '1) r_run_cycles <= r_run_cycles + 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        if (!valid_o[c] && ready_i[c] && r_stall[c] != '1) r_stall[c] <= r_stall[c] + 1'b1;
    end
  end

  assign run_cycles_o = r_run_cycles;
  assign stall_cnt_o  = r_stall;
`endif
endmodule

// File: tb/tb_cgra_input_stream_engine.sv
// Bench for cgra_input_stream_engine (default parameters). A memory model
// answers reads in order after a configurable latency; the reference model is
// the list of byte addresses each channel must read (base + k*stride, 32-bit
// wrap) and the words each channel must deliver in that order.
module tb_cgra_input_stream_engine;
  localparam int NC = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           start_i = 1'b0;
  logic [NC*32-1:0] base_addr_i = '0;
  logic [NC*16-1:0] size_i = '0;
  logic [NC*16-1:0] stride_i = '0;
  logic           busy_o, done_o, mem_req_valid_o, mem_rsp_ready_o;
  logic           mem_req_ready_i = 1'b0;
  logic [31:0]    mem_req_addr_o;
  logic           mem_rsp_valid_i = 1'b0;
  logic [31:0]    mem_rsp_data_i = '0;
  logic [NC*32-1:0] data_o;
  logic [NC-1:0]  valid_o;
  logic [NC-1:0]  ready_i = '0;

  cgra_input_stream_engine dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .size_i(size_i), .stride_i(stride_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_ready_o(mem_rsp_ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_fail = 0;
  // reference model
  logic [31:0] ea [NC][64];
  int ea_n [NC], ea_h [NC], dh [NC];
  int rq_due [$];
  logic [31:0] rq_addr [$];
  int n_out = 0, cyc = 0, n_done = 0, d0 = 0, done_cyc = 0, start_cyc = 0;
  int rr_exp = 0, stall_left = 0, junk_rsp = 0;
  bit strict_rr = 0, start_pend = 0, prev_pend = 0;
  logic [31:0] prev_addr = '0;
  int rdy_pct = 100, out_pct = 100, lat_lo = 1, lat_hi = 1;
  logic [NC-1:0] hold_mask = '0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int c, input logic [31:0] base, input int sz, input int st);
    logic [31:0] a;
    base_addr_i[c*32 +: 32] = base;
    size_i[c*16 +: 16]      = 16'(sz);
    stride_i[c*16 +: 16]    = 16'(st);
    a = base;
    for (int k = 0; k < sz; k++) begin
      ea[c][k] = a;
      a = a + 32'(st);
    end
    ea_n[c] = sz; ea_h[c] = 0; dh[c] = 0;
  endtask

  task automatic go();
    start_pend = 1; d0 = n_done; rr_exp = 0;
  endtask

  task automatic on_req(input logic [31:0] addr);
    int c = -1;
    for (int i = 0; i < NC; i++)
      if (c < 0 && ea_h[i] < ea_n[i] && ea[i][ea_h[i]] == addr) c = i;
    chk("req_addr_known", 32'(c >= 0), 1);
    if (c >= 0) begin
      if (strict_rr) begin
        chk("rr_order", c, rr_exp);
        rr_exp = (rr_exp + 1) % NC;
      end
      ea_h[c]++;
    end
    n_out++;
    chk("outstanding_le_4", 32'(n_out <= 4), 1);
    rq_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
    rq_addr.push_back(addr);
  endtask

  task automatic on_pop(input int c);
    chk("pop_expected", 32'(dh[c] < ea_n[c]), 1);
    if (dh[c] < ea_n[c]) begin
      chk($sformatf("ch%0d_data", c), data_o[c*32 +: 32], mdata(ea[c][dh[c]]));
      dh[c]++;
    end
  endtask

  // One clock: sample at the falling edge, drive inputs for the next rising
  // edge, and account for the transfers that edge will perform.
  task automatic tick();
    @(negedge clk_i);
    start_i = start_pend;
    if (start_pend) start_cyc = cyc;
    start_pend = 0;
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (prev_pend) begin
      chk("req_hold_valid", mem_req_valid_o, 1);
      chk("req_hold_addr", mem_req_addr_o, prev_addr);
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = $urandom;
    if (junk_rsp > 0) begin
      mem_rsp_valid_i = 1'b1;
      junk_rsp--;
    end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = mdata(rq_addr[0]);
      void'(rq_due.pop_front());
      void'(rq_addr.pop_front());
      n_out--;
    end
    if (stall_left > 0) begin
      mem_req_ready_i = 1'b0;
      stall_left--;
    end else mem_req_ready_i = ($urandom_range(99) < rdy_pct);
    for (int c = 0; c < NC; c++)
      ready_i[c] = !hold_mask[c] && ($urandom_range(99) < out_pct);
    if (mem_req_valid_o && mem_req_ready_i) on_req(mem_req_addr_o);
    prev_pend = mem_req_valid_o && !mem_req_ready_i;
    prev_addr = mem_req_addr_o;
    for (int c = 0; c < NC; c++)
      if (valid_o[c] && ready_i[c]) on_pop(c);
    cyc++;
  endtask

  task automatic run_to_done(input string tag, input int bound);
    int t = 0;
    while (n_done == d0 && t < bound) begin tick(); t++; end
    tick();
    chk({tag, "_done_once"}, n_done - d0, 1);
    chk({tag, "_idle_after"}, busy_o, 0);
    for (int c = 0; c < NC; c++) begin
      chk({tag, "_reqs"}, ea_h[c], ea_n[c]);
      chk({tag, "_words"}, dh[c], ea_n[c]);
    end
  endtask

  initial begin
    int t, tot;
    bit others;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_req_valid", mem_req_valid_o, 0);
    chk("rst_req_addr", mem_req_addr_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o[31:0] | data_o[63:32] | data_o[95:64] | data_o[127:96], 0);
    chk("rsp_ready_tied", mem_rsp_ready_o, 1);
    rst_ni = 1'b1;

    // single channel, always-ready memory, 1-cycle response
    cfg(0, 32'h8000_0000, 8, 4);
    for (int c = 1; c < NC; c++) cfg(c, 32'h1000_0000 * c, 0, 4);
    go(); run_to_done("t1", 200);
    chk("t1_last_addr", ea[0][7], 32'h8000_001C);

    // four channels, strict round-robin interleave
    strict_rr = 1;
    cfg(0, 32'h8000_0000, 8, 8); cfg(1, 32'h8100_0004, 8, 8);
    cfg(2, 32'h8200_0008, 8, 8); cfg(3, 32'h8300_000C, 8, 8);
    go(); run_to_done("t2", 400);
    strict_rr = 0;
    tot = 0;
    for (int c = 0; c < NC; c++) tot += ea_h[c];
    chk("t2_total_reqs", tot, 32);

    // backpressure on channel 1
    hold_mask = 4'b0010;
    for (int c = 0; c < NC; c++) cfg(c, 32'h2000_0000 * (c + 1), 8, 4);
    go();
    t = 0; others = 0;
    while (!others && t < 400) begin
      tick(); t++;
      others = (dh[0] == 8) && (dh[2] == 8) && (dh[3] == 8);
    end
    repeat (10) tick();
    chk("t3_others_done", 32'(others), 1);
    chk("t3_ch1_credit_cap", 32'(ea_h[1] <= 4), 1);
    chk("t3_ch1_blocked_words", dh[1], 0);
    chk("t3_no_early_done", n_done - d0, 0);
    chk("t3_still_busy", busy_o, 1);
    hold_mask = '0;
    run_to_done("t3", 400);

    // memory stall plus 6-cycle responses
    lat_lo = 6; lat_hi = 6; out_pct = 70;
    for (int c = 0; c < NC; c++) cfg(c, 32'h4000_0000 + 32'h0100_0000 * c, 6, 4);
    go(); tick(); tick();
    stall_left = 10;
    run_to_done("t4", 600);
    lat_lo = 1; lat_hi = 6; rdy_pct = 60;
    for (int c = 0; c < NC; c++) cfg(c, 32'h4800_0000 + 32'h0100_0000 * c, 8, 12);
    go(); run_to_done("t4r", 800);
    rdy_pct = 100; lat_lo = 1; lat_hi = 1; out_pct = 100;

    // address wrap-around
    cfg(0, 32'hFFFF_FFF8, 4, 4);
    for (int c = 1; c < NC; c++) cfg(c, 32'h1000_0000 * c, 0, 4);
    chk("t5_wrap_addr2", ea[0][2], 32'h0000_0000);
    go(); run_to_done("t5", 200);

    // reset with two reads in flight, late responses ignored
    lat_lo = 6; lat_hi = 6;
    for (int c = 0; c < NC; c++) cfg(c, 32'h5000_0000 + 32'h0100_0000 * c, 8, 4);
    go();
    t = 0;
    while (n_out < 2 && t < 40) begin tick(); t++; end
    @(posedge clk_i); #1;
    chk("t6_two_inflight", n_out, 2);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_req_valid", mem_req_valid_o, 0);
    chk("t6_rst_req_addr", mem_req_addr_o, 0);
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_done", done_o, 0);
    rq_due.delete(); rq_addr.delete(); n_out = 0; prev_pend = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    junk_rsp = 2;
    repeat (5) begin
      tick();
      chk("t6_late_rsp_valid", valid_o, 0);
      chk("t6_late_rsp_busy", busy_o, 0);
    end
    lat_lo = 1; lat_hi = 3;
    for (int c = 0; c < NC; c++) cfg(c, 32'h6000_0000 + 32'h0100_0000 * c, 5, 8);
    go(); run_to_done("t6", 400);

    // all sizes zero: done two cycles after start
    for (int c = 0; c < NC; c++) cfg(c, 32'h7000_0000, 0, 4);
    go(); run_to_done("t7", 10);
    chk("t7_done_latency", done_cyc - start_cyc, 2);

    // randomized configurations and traffic
    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < NC; c++)
        cfg(c, (32'(c + 1) << 28) | ($urandom & 32'h00FF_FFFC),
            $urandom_range(12, 0), 4 * $urandom_range(16, 0));
      lat_lo = 1; lat_hi = $urandom_range(6, 1);
      rdy_pct = $urandom_range(100, 50); out_pct = $urandom_range(100, 40);
      go(); run_to_done("rnd", 2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
